// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial full subtractor driven from push buttons.
//
// The operator enters A and B one bit pair at a time, LSB first, on KEY[0] and KEY[1].
// Each press of KEY[2] commits one pair through a single borrow flip-flop. After WIDTH
// steps the difference A-B and the final borrow stay on the LEDs until KEY[3] clears them.
//
// Parameters:
//   WIDTH            operand/difference width, 1..3
//   DEBOUNCE_CYCLES  stable cycles needed before a debounced key level changes
// Ports:
//   CLK    input      system clock (50 MHz)
//   RST_N  input      asynchronous active-low reset; release synchronized internally
//   KEY    input [3]  active-low keys: 0 = A bit, 1 = B bit, 2 = step, 3 = clear
//   LED    output [3] active-low: [WIDTH-1:0] = difference, [3] = borrow, others off
// Build option:
//   SERIAL_SUBTRACTOR_DEBOUNCE_EN  defined: per-key debounce counters are built;
//                                  undefined: debounced level = synchronizer output.

module serial_subtractor #(
  parameter int unsigned WIDTH           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] KEY,
  output logic [3:0] LED
);

  typedef enum logic {StCollect, StDone} state_e;

  localparam logic [1:0] LastCnt = 2'(WIDTH - 1);

  // Reset: assert asynchronously, release after two clock edges.
  logic rst_meta_q, rst_n;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rst_meta_q <= 1'b0;
      rst_n      <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n      <= rst_meta_q;
    end
  end

  // Key synchronizers; keys are active-low, so "released" is 1.
  logic [3:0] sync1_q, sync2_q, db_q;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'b1111;
      sync2_q <= 4'b1111;
    end else begin
      sync1_q <= KEY;
      sync2_q <= sync1_q;
    end
  end

`ifdef SERIAL_SUBTRACTOR_DEBOUNCE_EN
  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0] cnt_q [4];

  // The counter runs only while the synchronized level disagrees with the debounced one,
  // so any bounce back to the old level restarts the count.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      db_q <= 4'b1111;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntLast) begin
          cnt_q[i] <= '0;
          db_q[i]  <= sync2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^DEBOUNCE_CYCLES;
  assign db_q       = sync2_q;
`endif

  // Active-high debounced levels.
  logic a, b, step_lvl, clr_lvl;
  assign a        = ~db_q[0];
  assign b        = ~db_q[1];
  assign step_lvl = ~db_q[2];
  assign clr_lvl  = ~db_q[3];

  // Registered press pulses; releases produce nothing.
  logic step_prev_q, clr_prev_q, step_p, clr_p;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      step_prev_q <= 1'b0;
      clr_prev_q  <= 1'b0;
      step_p      <= 1'b0;
      clr_p       <= 1'b0;
    end else begin
      step_prev_q <= step_lvl;
      clr_prev_q  <= clr_lvl;
      step_p      <= step_lvl & ~step_prev_q;
      clr_p       <= clr_lvl & ~clr_prev_q;
    end
  end

  // Datapath.
  state_e           state_q;
  logic [WIDTH-1:0] diff_q, diff_shift;
  logic [1:0]       bit_cnt_q;
  logic             bor_q, d, bor_nxt;

  always_comb begin
    d       = a ^ b ^ bor_q;
    bor_nxt = (~a & b) | (~(a ^ b) & bor_q);
    // New bit enters at the MSB; after WIDTH steps the LSB sits at bit 0.
    diff_shift = '0;
    for (int i = 0; i < int'(WIDTH) - 1; i++) diff_shift[i] = diff_q[i+1];
    diff_shift[WIDTH-1] = d;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StCollect;
      diff_q    <= '0;
      bor_q     <= 1'b0;
      bit_cnt_q <= 2'd0;
    end else if (clr_p) begin
      // Clear wins over a coincident step.
      state_q   <= StCollect;
      diff_q    <= '0;
      bor_q     <= 1'b0;
      bit_cnt_q <= 2'd0;
    end else if (step_p && state_q == StCollect && bit_cnt_q <= LastCnt) begin
      diff_q    <= diff_shift;
      bor_q     <= bor_nxt;
      bit_cnt_q <= bit_cnt_q + 2'd1;
      if (bit_cnt_q == LastCnt) state_q <= StDone;
    end
  end

  // LEDs straight from the registers; unused difference positions stay off.
  logic [2:0] led_low;

  always_comb begin
    led_low = 3'b111;
    for (int i = 0; i < int'(WIDTH); i++) led_low[i] = ~diff_q[i];
  end

  assign LED = {~bor_q, led_low};

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

`ifdef SERIAL_SUBTRACTOR_DEBOUNCE_EN
  localparam int DbN = 8;
`else
  localparam int DbN = 0;
`endif
  // Press edge to LED update: 2 sync + debounce + 1 pulse + 1 register.
  localparam int Lat  = 4 + DbN;
  localparam int Hold = Lat + 8;

  typedef struct {
    logic [3:0] led;
    int         due;
    string      name;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] key;
  logic [3:0] led;

  int   cyc;
  int   n_vec;
  int   n_err;
  exp_t sb[$];
  logic [3:0] exp_led;

  serial_subtractor #(
    .WIDTH          (3),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .KEY  (key),
    .LED  (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every due expectation on the falling edge.
  initial begin
    n_vec = 0;
    n_err = 0;
  end

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if (e.due != cyc || led !== e.led) begin
        n_err++;
        $display("FAIL %s: LED=%b required %b (cycle %0d, due %0d)",
                 e.name, led, e.led, cyc, e.due);
      end
    end
  end

  task automatic push(input logic [3:0] v, input int due, input string nm);
    exp_t e;
    e.led  = v;
    e.due  = due;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() > 0 && k < 1000) begin
      tick(1);
      k++;
    end
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations pending, required 0", sb.size());
      $fatal(1);
    end
  endtask

  // One key action; LED must hold the old value until exactly Lat cycles after the press.
  task automatic act(input logic a, input logic b, input logic stp, input logic clr,
                     input logic [3:0] nxt, input string nm);
    int p;
    key[0] = ~a;
    key[1] = ~b;
    tick(Hold);
    p = cyc;
    key[2] = ~stp;
    key[3] = ~clr;
    push(exp_led, p + Lat - 1, {nm, " pre"});
    push(nxt, p + Lat, nm);
    tick(Hold);
    key[3:2] = 2'b11;
    tick(Hold);
    push(nxt, cyc + 1, {nm, " held"});
    exp_led = nxt;
  endtask

  task automatic step(input logic a, input logic b, input logic [3:0] nxt, input string nm);
    act(a, b, 1'b1, 1'b0, nxt, nm);
  endtask

  task automatic clear(input string nm);
    act(1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, nm);
  endtask

  task automatic five_minus_three(input string nm);
    step(1'b1, 1'b1, 4'b1111, {nm, " s1"});
    step(1'b0, 1'b1, 4'b0011, {nm, " s2"});
    step(1'b1, 1'b0, 4'b1101, {nm, " s3"});
  endtask

  initial begin
    exp_led = 4'b1111;
    rst_n   = 1'b0;
    key     = 4'b0000;
    tick(3);
    push(4'b1111, cyc + 1, "reset during");
    tick(3);
    key = 4'b1111;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    push(4'b1111, cyc + 1, "reset after");
    drain();

`ifdef SERIAL_SUBTRACTOR_DEBOUNCE_EN
    for (int g = 0; g < 3; g++) begin
      key[2] = 1'b0;
      tick(5);
      key[2] = 1'b1;
      tick(12);
    end
    push(4'b1111, cyc + 1, "glitch no step");
    drain();
`endif

    // 5 - 3 = 2, no borrow; a fourth step is ignored.
    five_minus_three("5-3");
    step(1'b1, 1'b1, 4'b1101, "5-3 extra step");
    clear("clear after done");

    // 3 - 5 = 6 mod 8, borrow out.
    step(1'b1, 1'b1, 4'b1111, "3-5 s1");
    step(1'b1, 1'b0, 4'b1011, "3-5 s2");
    step(1'b0, 1'b1, 4'b0001, "3-5 s3");
    step(1'b0, 1'b1, 4'b0001, "3-5 extra step");
    clear("clear 3-5");

    // Simultaneous step and clear mid-entry: clear wins, count restarts.
    step(1'b1, 1'b1, 4'b1111, "prio s1");
    step(1'b0, 1'b1, 4'b0011, "prio s2");
    act(1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, "step+clear");
    five_minus_three("after prio");
    clear("clear prio");

    // Reset mid-entry takes effect without waiting for a clock edge.
    step(1'b1, 1'b1, 4'b1111, "mid s1");
    step(1'b0, 1'b1, 4'b0011, "mid s2");
    drain();
    rst_n = 1'b0;
    push(4'b1111, cyc, "async reset");
    tick(3);
    rst_n = 1'b1;
    tick(4);
    exp_led = 4'b1111;
    five_minus_three("after reset");

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial full subtractor for the EasyFPGA EP4CE6 kit; the sequential inverse-direction counterpart of the push-button adder demos. The operator enters operand bits A and B on two keys, LSB first, and a step key commits each bit pair. One borrow flip-flop carries between steps. After WIDTH steps the difference A−B and the final borrow stay on the active-low LEDs until cleared.

## Interface
- WIDTH, default 3: operand/difference width in bits; legal range 1..3.
- DEBOUNCE_CYCLES, default 1000000: number of consecutive stable clock cycles a synchronized key must hold before its debounced level changes (20 ms at 50 MHz).
- CLK  input  1  system clock, 50 MHz.
- RST_N  input  1  reset, asynchronous assert, active-low; release synchronized internally.
- KEY  input  4  push buttons, active-low:
  - KEY[0] = A bit.
  - KEY[1] = B bit.
  - KEY[2] = step.
  - KEY[3] = clear.
- LED  output  4  active-low indicators:
  - LED[WIDTH-1:0] = ~difference register.
  - LED[3] = ~borrow.
  - LED bits WIDTH..2 are driven 1 (off).

## Operation
- Input path per key:
  - 2-flop synchronizer.
  - Debouncer (see Configuration).
  - Inversion to an active-high level: a, b, step_lvl, clr_lvl.
- Edge detect: step_p and clr_p are one-cycle pulses on the 0→1 transition of step_lvl and clr_lvl (the key press). Releases generate nothing.
- State machine:
  - COLLECT (reset state): on step_p with bit_cnt < WIDTH:
    - d = a ^ b ^ bor.
    - bor <= (~a & b) | (~(a ^ b) & bor).
    - diff <= {d, diff[WIDTH-1:1]} (shift right; MSB insert).
    - bit_cnt += 1.
    - Move to DONE when bit_cnt reaches WIDTH.
  - DONE: diff and bor frozen; step_p is ignored.
  - Any state: clr_p clears diff, bor and bit_cnt to 0 and returns to COLLECT.
- Inputs a and b are sampled in the step_p cycle. Key changes between steps have no effect.
- Result is the unsigned difference modulo 2^WIDTH; final bor = 1 iff A < B.
- Partial results are visible during COLLECT: LEDs show the shifted-in bits and the running borrow.
- Simultaneous step_p and clr_p: clear wins; the step is discarded.
- Reset mid-operation: all registers and debouncer counters return to reset values immediately. An entry in progress is lost.
- Reset values:
  - Registers: diff = 0, bor = 0, bit_cnt = 0, state = COLLECT.
  - Synchronizer and debounced levels = released; debouncer counters = 0.
  - LED = 4'b1111.

## Timing
- Key to debounced level: 2 cycles (synchronizer) + DEBOUNCE_CYCLES.
- Debounced rise to step_p/clr_p: 1 cycle.
- step_p/clr_p to register and LED update: 1 cycle. LEDs are driven combinationally from registers; there is no output register stage.
- Key bounces shorter than DEBOUNCE_CYCLES produce no pulse.
- One press produces exactly one step_p, regardless of hold time.

## Configuration
- SERIAL_SUBTRACTOR_DEBOUNCE_EN:
  - Defined: the debounce counter per key is instantiated. The debounced level follows the synchronized level only after DEBOUNCE_CYCLES stable cycles; the counter restarts on any change.
  - Undefined: no counters; the debounced level equals the synchronizer output, and DEBOUNCE_CYCLES is unused. Used for fast simulation and for bounce-free stimulus.

## Test plan
- Reset: RST_N low with arbitrary KEY → LED = 4'b1111 during and after reset; the first step uses bor = 0.
- 5−3, WIDTH=3: steps (a,b) = (1,1), (0,1), (1,0) → after the 3rd step diff = 3'b010, bor = 0, LED = 4'b1101; a 4th press leaves LED unchanged.
- 3−5, WIDTH=3: steps (1,1), (1,0), (0,1) → diff = 3'b110, bor = 1, LED = 4'b0001.
- Clear priority: press step and clear in the same debounced cycle mid-entry → diff = 0, bor = 0, bit_cnt = 0, LED = 4'b1111.
- Debounce (macro defined, DEBOUNCE_CYCLES = 8): 5-cycle glitches on KEY[2] → no step. A 20-cycle hold → exactly one step, with the LED update 2+8+1+1 cycles after the press edge.
- Reset mid-entry: assert RST_N after 2 steps → LED = 4'b1111 asynchronously. After release, a full 3-step entry of 5−3 yields LED = 4'b1101.
